// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: sequential front-end for the combinational 8-bit ALU.
// Commands arrive on a valid/ready port into a small FIFO, are driven onto
// the ALU pins for SETTLE_CYCLES, and the captured result/flags are returned
// in order on a valid/ready response port. Opcodes 12..15 are rejected with
// an illegal response and never reach the ALU pins.
// Optional build macro ALU_FLAG_CHECK_EN: adds a zero-flag consistency check
// reported on flag_err alongside each response; without it flag_err is 0.
module alu_cmd_issuer #(
    parameter int WIDTH         = 8,
    parameter int SHAMT_W       = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHAMT_W-1:0] cmd_shift,
    output logic [3:0]         alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHAMT_W-1:0] alu_shiftValue,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [2:0]         rsp_flags,
    output logic               rsp_illegal,
    output logic               flag_err,
    output logic               busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef struct packed {
        logic [3:0]         op;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [SHAMT_W-1:0] sh;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    // ---------------- command FIFO ----------------
    cmd_t        mem_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, pop;
    cmd_t        head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready  = rst_n && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem_q[rd_ptr_q[PW-1:0]];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b, sh: cmd_shift};
    end

    // Pointers carry a wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------- issue FSM ----------------
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         alu_op_q;
    logic [WIDTH-1:0]   alu_in1_q, alu_in2_q;
    logic [SHAMT_W-1:0] alu_sh_q;
    logic               rsp_valid_q, rsp_illegal_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic [2:0]         rsp_flags_q;
    logic               head_illegal, capture, ill_issue;

    // A pop happens from IDLE, or from RESP on the handshake so there is no bubble.
    assign pop          = !fifo_empty && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign head_illegal = (head.op >= 4'd12);
    assign ill_issue    = pop && head_illegal;
    assign capture      = (state_q == DRIVE) && (cnt_q == CW'(SETTLE_CYCLES - 1));

    // Dispatch, settle counting, capture and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alu_op_q      <= '0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_sh_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
        end else if (pop) begin
            if (head_illegal) begin
                // ALU pins keep their previous contents for a rejected opcode.
                rsp_valid_q   <= 1'b1;
                rsp_illegal_q <= 1'b1;
                rsp_result_q  <= '0;
                rsp_flags_q   <= '0;
                state_q       <= RESP;
            end else begin
                alu_op_q    <= head.op;
                alu_in1_q   <= head.a;
                alu_in2_q   <= head.b;
                alu_sh_q    <= head.sh;
                cnt_q       <= '0;
                rsp_valid_q <= 1'b0;
                state_q     <= DRIVE;
            end
        end else begin
            case (state_q)
                DRIVE: begin
                    if (capture) begin
                        rsp_result_q  <= alu_result;
                        rsp_flags_q   <= {alu_overflow, alu_zero, alu_carry};
                        rsp_illegal_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAG_CHECK_EN
    logic flag_err_q;

    // Zero flag must agree with the result; verdict travels with the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         flag_err_q <= 1'b0;
        else if (capture)   flag_err_q <= (alu_zero != (alu_result == '0));
        else if (ill_issue) flag_err_q <= 1'b0;
    end

    assign flag_err = flag_err_q;
`else
    assign flag_err = 1'b0;
`endif

    assign alu_opcode     = alu_op_q;
    assign alu_input1     = alu_in1_q;
    assign alu_input2     = alu_in2_q;
    assign alu_shiftValue = alu_sh_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_flags      = rsp_flags_q;
    assign rsp_illegal    = rsp_illegal_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Sequential front-end that drives the combinational 8-bit ALU. It accepts operation commands over a valid/ready port and buffers them in a small FIFO. It presents each command on the ALU's opcode/input1/input2/shiftValue pins, waits a fixed settle time, then captures result and flags. It returns them in order over a valid/ready response port. It is the initiator side of the ALU operand/result interface.

Parameters:
WIDTH, 8, operand/result width
SHAMT_W, 5, shift-amount width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
SETTLE_CYCLES, 1, cycles ALU inputs are held before result capture (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at edge
cmd_opcode  in  4  ALU opcode (0..11 legal)
cmd_a  in  WIDTH  operand 1
cmd_b  in  WIDTH  operand 2
cmd_shift  in  SHAMT_W  shift amount
alu_opcode  out  4  registered to ALU opcode
alu_input1  out  WIDTH  registered to ALU input1
alu_input2  out  WIDTH  registered to ALU input2
alu_shiftValue  out  SHAMT_W  registered to ALU shiftValue
alu_result  in  WIDTH  ALU result
alu_carry / alu_zero / alu_overflow  in  1 each  ALU flags
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready at edge
rsp_result  out  WIDTH  captured result
rsp_flags  out  3  {overflow, zero, carry}
rsp_illegal  out  1  opcode 12..15 rejected
flag_err  out  1  see Optional Feature
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): FSM=IDLE, FIFO empty, all outputs 0; cmd_ready forced 0 while rst_n low; in-flight command dropped, no response issued.
- cmd_ready = !fifo_full (rst_n high). Push and pop on the same edge are allowed; count is unchanged.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: FIFO non-empty -> pop. Legal opcode: load alu_* regs, counter=0, go to DRIVE. Illegal opcode: alu_* unchanged, rsp_result=0, rsp_flags=0, rsp_illegal=1, rsp_valid=1, go to RESP.
- DRIVE: counter increments each cycle. At the edge where counter==SETTLE_CYCLES-1: capture alu_result and flags into rsp_*, rsp_illegal=0, rsp_valid=1, go to RESP.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake:
  - FIFO non-empty -> same-edge pop, handled as in IDLE (no bubble).
  - FIFO empty -> rsp_valid=0, go to IDLE.
- Latency, empty FIFO and IDLE, accept at edge E0:
  - alu_* valid after E1.
  - rsp_valid after E1+SETTLE_CYCLES for a legal opcode; after E1 for an illegal one.
- alu_* hold their last value in IDLE/RESP; they are not cleared.
- Responses are strictly in command order. Capacity is FIFO_DEPTH buffered plus one in flight.
- FIFO pointers are log2(FIFO_DEPTH) bits with an extra wrap bit for full/empty and wrap naturally.
- No arithmetic on data; width is passed through unchanged.

Optional Feature:
ALU_FLAG_CHECK_EN
- Defined: at capture, flag_err=1 if alu_zero != (alu_result==0). flag_err is registered with the response and held with it; it is cleared to 0 at the next capture or an illegal response.
- Undefined: flag_err tied 0; no comparator.

Test Plan:
- ADD, a=8'h0F, b=8'h01, SETTLE_CYCLES=1, model ALU -> alu_opcode=0 and inputs driven 1 cycle after accept; rsp_valid 2 cycles after accept; rsp_result=8'h10, rsp_flags=3'b000.
- rsp_ready=0, issue 6 back-to-back SUBs -> 5 accepted, then cmd_ready=0. Then rsp_ready=1 -> 5 responses in order, one per SETTLE_CYCLES+1 cycles, cmd_ready returns 1.
- opcode 4'd13 -> rsp_valid 1 cycle after accept, rsp_illegal=1, rsp_result=0, flags=0, alu_* unchanged.
- Hold rsp_ready=0 for 10 cycles with rsp_valid=1 -> rsp_result/flags/illegal stable every cycle.
- Assert rst_n=0 while in DRIVE with 2 commands queued -> all outputs 0 immediately, no response after release, busy=0, cmd_ready=1.
- With ALU_FLAG_CHECK_EN, model returns result=8'h00 with zero=0 -> flag_err=1 with that response. Next correct response -> flag_err=0.
